// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-way TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux4_if.sv
// Word-stream input and frame output bundle for tdm_demux4.
// The slave side is the demultiplexer; the master side is the producer/consumer pair.
interface tdm_demux4_if #(
    parameter int N       = 8,
    parameter int COUNT_W = 8
);
    import tdm_pkg::*;

    logic [N-1:0]       in_data;
    logic               in_valid;
    logic               in_first;
    logic               in_ready;
    logic [N-1:0]       out0;
    logic [N-1:0]       out1;
    logic [N-1:0]       out2;
    logic [N-1:0]       out3;
    logic               frame_valid;
    logic               frame_ready;
    logic [SLOT_W-1:0]  slot;
    logic               sync_err;
    logic [COUNT_W-1:0] frame_count;

    modport master (
        output in_data, in_valid, in_first, frame_ready,
        input  in_ready, out0, out1, out2, out3, frame_valid, slot, sync_err, frame_count
    );

    modport slave (
        input  in_data, in_valid, in_first, frame_ready,
        output in_ready, out0, out1, out2, out3, frame_valid, slot, sync_err, frame_count
    );

endinterface : tdm_demux4_if

// File: rtl/demux_lane_en.sv
// One-hot lane write-enable decoder, gated by the accept strobe.
module demux_lane_en
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]    i_slot,
    input  logic                 i_accept,
    output logic [NUM_LANES-1:0] o_en
);

    // decode the target slot into a single lane enable
    always_comb begin
        o_en = '0;
        if (i_accept) begin
            case (i_slot)
                2'd0:    o_en = 4'b0001;
                2'd1:    o_en = 4'b0010;
                2'd2:    o_en = 4'b0100;
                default: o_en = 4'b1000;
            endcase
        end
    end

endmodule : demux_lane_en

// File: rtl/tdm_demux4.sv
// 4-way TDM demultiplexer: steers a serial word stream round-robin into four
// lane registers and presents each completed set as a frame.
//
// state | meaning
// FILL  | collecting words into lanes; in_ready=1
// FULL  | complete frame held on out0..out3; waits for frame_ready
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int N       = 8,
    parameter int COUNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux4_if.slave    bus
);

    tdm_state_t          r_state;
    tdm_state_t          w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [SLOT_W-1:0]   w_wr_slot;
    logic [N-1:0]        r_lane [NUM_LANES];
    logic                r_sync_err;
    logic [COUNT_W-1:0]  r_frame_count;
    logic                w_ready;
    logic                w_accept;
    logic                w_deliver;
    logic [NUM_LANES-1:0] w_lane_en;

    assign w_ready   = (r_state == FILL) | bus.frame_ready;
    assign w_accept  = bus.in_valid & w_ready;
    assign w_deliver = (r_state == FULL) & bus.frame_ready;

    // A realignment marker always restarts at lane 0; in FULL slot is already 0.
    assign w_wr_slot = bus.in_first ? '0 : r_slot;

    demux_lane_en u_lane_en (
        .i_slot   (w_wr_slot),
        .i_accept (w_accept),
        .o_en     (w_lane_en)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    // next-state and next-slot logic
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (bus.in_first) begin
                        w_slot_nxt = 2'd1;
                    end else if (r_slot == 2'd3) begin
                        w_slot_nxt  = 2'd0;
                        w_state_nxt = FULL;
                    end else begin
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
            end
            FULL: begin
                if (bus.frame_ready) begin
                    w_state_nxt = FILL;
                    if (w_accept) w_slot_nxt = 2'd1;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_slot_nxt  = '0;
            end
        endcase
    end

    // slot pointer, realignment error pulse and delivered-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot        <= '0;
            r_sync_err    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_slot     <= w_slot_nxt;
            r_sync_err <= w_accept & bus.in_first & (r_state == FILL) & (r_slot != 2'd0);
            if (w_deliver) r_frame_count <= r_frame_count + COUNT_W'(1);
        end
    end

    // lane registers; never cleared after consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_lane_en[i]) r_lane[i] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.frame_valid = (r_state == FULL);
    assign bus.slot        = r_slot;
    assign bus.sync_err    = r_sync_err;
    assign bus.frame_count = r_frame_count;
    assign bus.out0        = r_lane[0];
    assign bus.out1        = r_lane[1];
    assign bus.out2        = r_lane[2];
    assign bus.out3        = r_lane[3];

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus randomized traffic, both
// checked every cycle against a frame-level reference model.
module tb_tdm_demux4;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux4_if #(.N(8), .COUNT_W(8)) b1 ();
    tdm_demux4_if #(.N(8), .COUNT_W(2)) b2 ();

    assign b2.in_data     = b1.in_data;
    assign b2.in_valid    = b1.in_valid;
    assign b2.in_first    = b1.in_first;
    assign b2.frame_ready = b1.frame_ready;

    tdm_demux4 #(.N(8), .COUNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(b1.slave));
    tdm_demux4 #(.N(8), .COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    // reference model: a frame is being collected or is complete and waiting
    int         m_slot;
    bit         m_full;
    logic [7:0] m_lane [4];
    bit         m_serr;
    int         m_cnt;

    int errors = 0;
    int checks = 0;
    int serr_seen;
    int fv_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("frame_valid", 32'(b1.frame_valid), 32'(m_full));
        chk("slot",        32'(b1.slot),        32'(m_slot));
        chk("sync_err",    32'(b1.sync_err),    32'(m_serr));
        chk("frame_count", 32'(b1.frame_count), 32'(m_cnt % 256));
        chk("out0", 32'(b1.out0), 32'(m_lane[0]));
        chk("out1", 32'(b1.out1), 32'(m_lane[1]));
        chk("out2", 32'(b1.out2), 32'(m_lane[2]));
        chk("out3", 32'(b1.out3), 32'(m_lane[3]));
        chk("count_w2", 32'(b2.frame_count), 32'(m_cnt % 4));
        serr_seen += int'(b1.sync_err);
        fv_seen   += int'(b1.frame_valid);
    endtask

    task automatic step(input bit r, input bit v, input bit f, input logic [7:0] d, input bit fr);
        bit exp_rdy, acc;
        rst            = r;
        b1.in_valid    = v;
        b1.in_first    = f;
        b1.in_data     = d;
        b1.frame_ready = fr;
        #1;
        exp_rdy = !m_full || fr;
        if (!r) chk("in_ready", 32'(b1.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            m_full = 0; m_slot = 0; m_serr = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        end else begin
            m_serr = 0;
            if (m_full) begin
                if (fr) begin
                    m_cnt++;
                    m_full = 0;
                    if (acc) begin
                        m_lane[0] = d;
                        m_slot = 1;
                    end
                end
            end else if (acc) begin
                if (f) begin
                    m_serr = (m_slot != 0);
                    m_lane[0] = d;
                    m_slot = 1;
                end else begin
                    m_lane[m_slot] = d;
                    m_slot = (m_slot + 1) % 4;
                    if (m_slot == 0) m_full = 1;
                end
            end
        end
        #1;
        if (!r) check_all();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 8'h00, 0);
        check_all();
        serr_seen = 0;
        fv_seen   = 0;
    endtask

    initial begin
        bit         pv, pf, pfr, hold;
        logic [7:0] pd;
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        m_full = 0; m_slot = 0; m_serr = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        serr_seen = 0; fv_seen = 0;
        rst = 1'b1;
        b1.in_valid = 0; b1.in_first = 0; b1.in_data = 0; b1.frame_ready = 0;
        repeat (2) @(posedge clk);

        // reset state
        do_reset();
        chk("rst_frame_valid", 32'(b1.frame_valid), 32'd0);
        chk("rst_slot",        32'(b1.slot),        32'd0);
        chk("rst_out0",        32'(b1.out0),        32'd0);

        // basic frame
        step(0, 1, 1, 8'd1, 0);
        step(0, 1, 0, 8'd2, 0);
        step(0, 1, 0, 8'd3, 0);
        chk("basic_not_yet_valid", 32'(b1.frame_valid), 32'd0);
        step(0, 1, 0, 8'd4, 0);
        chk("basic_fv",   32'(b1.frame_valid), 32'd1);
        chk("basic_outs", {b1.out0, b1.out1, b1.out2, b1.out3}, 32'h01020304);
        chk("basic_slot", 32'(b1.slot), 32'd0);
        chk("basic_ready", 32'(b1.in_ready), 32'd0);
        chk("basic_serr_cnt", 32'(serr_seen), 32'd0);

        // backpressure
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h55, 0);
        chk("bp_outs",  {b1.out0, b1.out1, b1.out2, b1.out3}, 32'h01020304);
        chk("bp_ready", 32'(b1.in_ready), 32'd0);
        step(0, 1, 0, 8'h55, 1);
        chk("bp_count", 32'(b1.frame_count), 32'd1);
        chk("bp_out0",  32'(b1.out0), 32'h55);
        chk("bp_slot",  32'(b1.slot), 32'd1);

        // streaming
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1, (i == 0), 8'(10 + i), 1);
        chk("stream_fv_cycles", 32'(fv_seen), 32'd4);
        chk("stream_outs", {b1.out0, b1.out1, b1.out2, b1.out3}, {8'd22, 8'd23, 8'd24, 8'd25});
        step(0, 0, 0, 8'h00, 1);
        chk("stream_count", 32'(b1.frame_count), 32'd4);

        // realignment
        do_reset();
        step(0, 1, 1, 8'd7, 0);
        step(0, 1, 0, 8'd8, 0);
        step(0, 1, 1, 8'd9, 0);
        chk("realign_serr", 32'(b1.sync_err), 32'd1);
        chk("realign_slot", 32'(b1.slot), 32'd1);
        chk("realign_out0", 32'(b1.out0), 32'd9);
        step(0, 1, 0, 8'd10, 0);
        step(0, 1, 0, 8'd11, 0);
        step(0, 1, 0, 8'd12, 0);
        chk("realign_frame", {b1.out0, b1.out1, b1.out2, b1.out3}, {8'd9, 8'd10, 8'd11, 8'd12});
        chk("realign_serr_cnt", 32'(serr_seen), 32'd1);

        // reset mid-operation
        do_reset();
        step(0, 1, 1, 8'hA1, 0);
        step(0, 1, 0, 8'hA2, 0);
        step(1, 1, 0, 8'hA3, 0);
        chk("midrst_outs", {b1.out0, b1.out1, b1.out2, b1.out3}, 32'd0);
        chk("midrst_slot", 32'(b1.slot), 32'd0);
        chk("midrst_serr", 32'(b1.sync_err), 32'd0);
        serr_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 8'(8'hB0 + i), 0);
        chk("midrst_frame", {b1.out0, b1.out1, b1.out2, b1.out3}, 32'hB0B1B2B3);
        chk("midrst_serr_cnt", 32'(serr_seen), 32'd0);

        // frame counter wrap on the COUNT_W=2 instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 8'(k * 4 + i), 0);
            step(0, 0, 0, 8'h00, 1);
            chk("wrap_count", 32'(b2.frame_count), 32'(wrap_exp[k]));
        end

        // randomized traffic, producer holds its word until it is taken
        do_reset();
        hold = 0; pv = 0; pf = 0; pd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                pv = ($urandom_range(0, 3) != 0);
                pf = ($urandom_range(0, 9) == 0);
                pd = 8'($urandom);
            end
            pfr = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) begin
                step(1, pv, pf, pd, pfr);
                hold = 0;
            end else begin
                hold = pv && m_full && !pfr;
                step(0, pv, pf, pd, pfr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tdm_demux4

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiving end of a 4-way time-division-multiplexed word stream: accepts N-bit words one per cycle over a valid/ready handshake and steers them in round-robin order into four lane registers.
- Presents the completed set of four words as one frame with its own valid/ready handshake.
- Sits downstream of any 4:1 select path that serializes in0..in3 onto one bus, and restores the parallel view.

Parameters:
- N, 8, width of each data word and each lane output.
- COUNT_W, 8, width of the delivered-frame counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  incoming word.
- in_valid  input  1  in_data valid this cycle.
- in_first  input  1  qualifies in_data as slot 0 of a new frame (realignment marker).
- in_ready  output  1  block can accept a word this cycle.
- out0, out1, out2, out3  output  N each  lane registers; meaningful only while frame_valid=1.
- frame_valid  output  1  all four lanes hold a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- slot  output  2  index of the lane the next accepted word will fill.
- sync_err  output  1  one-cycle pulse: partial frame discarded on realignment.
- frame_count  output  COUNT_W  frames delivered (frame_valid & frame_ready), wraps modulo 2^COUNT_W.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=FILL, slot=0, out0..out3=0, frame_valid=0, sync_err=0, frame_count=0. rst has priority over all other events. Reset mid-frame drops any partial or held frame silently; no sync_err is raised.
- Accept: accept = in_valid & in_ready.
- Ready and valid timing:
  - in_ready = (state==FILL) | frame_ready. This is combinational from frame_ready, so the block can be drained and refilled in the same cycle.
  - frame_valid = (state==FULL), registered.
- FILL state:
  - On accept with in_first=0: lane[slot] <= in_data, then slot <= slot+1.
  - If the accepted word was at slot 3: slot <= 0 and state <= FULL. frame_valid rises on the next cycle, so latency is 1 cycle from the 4th accept to frame_valid=1.
  - On accept with in_first=1: lane0 <= in_data, slot <= 1, and any partially filled lanes are abandoned.
  - sync_err pulses high for exactly one cycle after that edge iff slot!=0 at the accepting edge.
  - in_first=1 with slot==0 is normal alignment: no error.
- FULL state:
  - out0..out3 hold stable until consumed. Accept is impossible unless frame_ready=1.
  - On frame_ready=1: frame_count increments.
  - If frame_ready=1 and no accept in the same cycle: state <= FILL.
  - If frame_ready=1 and accept in the same cycle: lane0 <= in_data, slot <= 1, state <= FILL. in_first is irrelevant here because slot is 0, so no sync_err.
- Lanes are not cleared after consumption. During FILL, outputs may show a mix of old and new words; consumers must qualify with frame_valid.
- in_valid=0: no state change except the frame_ready consumption above.
- in_valid=1 with in_ready=0: the word is not taken. The producer must hold in_data, in_valid and in_first stable until accepted.
- Throughput: sustained 1 word/cycle when frame_ready is held high. One frame every 4 cycles with no bubbles.
- frame_count wrap: the value 2^COUNT_W-1 followed by one delivery gives 0.

Decomposition:
- Package tdm_pkg:
  - NUM_LANES=4 and SLOT_W=2.
  - typedef enum logic {FILL, FULL} tdm_state_t.
- Sub-module demux_lane_en: combinational 2-to-4 one-hot decoder producing the lane write enables, gated by accept. All other logic lives in tdm_demux4.

Test Plan (N=8):
- Basic frame: reset, frame_ready=0, send 1,2,3,4 with in_first on word 1 → one cycle after the 4th accept, frame_valid=1, out0..3=1,2,3,4, slot=0, in_ready=0, sync_err never high.
- Backpressure: frame held with frame_ready=0 for 5 cycles while in_valid=1 with 8'h55 → outputs unchanged, in_ready=0. frame_ready=1 for 1 cycle → frame_count=1, 8'h55 lands in out0, slot=1.
- Streaming: frame_ready tied 1, send 16 consecutive words 10..25 → frame_valid asserted for 4 frames with no gap cycles, frame_count=4, last frame out0..3=22,23,24,25.
- Realignment: send 7,8 then 9 with in_first=1 → sync_err pulses exactly once, slot=1, out0=9. Then 10,11,12 → frame 9,10,11,12.
- Reset mid-operation: after 2 accepted words, assert rst 1 cycle → all outputs 0, slot=0. Next 4 words form a clean frame with no sync_err.
- Counter wrap with COUNT_W=2: deliver 5 frames → frame_count sequence 1,2,3,0,1.
